// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store definitions: func3 codes, load FSM encoding and
// access-size helpers used by the load unit and its byte aligner.
package rv32i_pkg;

    localparam logic [6:0] OPCODE_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RD0,
        LD_WAIT0,
        LD_RD1,
        LD_WAIT1,
        LD_WB
    } load_state_e;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    function automatic logic [2:0] load_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return 3'd1;
            F3_LH, F3_LHU: return 3'd2;
            default:       return 3'd4;
        endcase
    endfunction

    // An access spills into the next word when its last byte lies past byte 3.
    function automatic logic load_split(input logic [2:0] f3, input logic [1:0] off);
        return ({1'b0, off} + load_size(f3)) > 3'd4;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: selects the addressed bytes from a two-word
// window and sign- or zero-extends them according to func3.
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] d1,
    input  logic [31:0] d0,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] result
);

    logic [31:0] sh;

    assign sh = 32'({d1, d0} >> {off, 3'b000});

    always_comb begin
        result = 32'd0;
        case (func3)
            F3_LB:   result = {{24{sh[7]}}, sh[7:0]};
            F3_LH:   result = {{16{sh[15]}}, sh[15:0]};
            F3_LW:   result = sh;
            F3_LBU:  result = {24'd0, sh[7:0]};
            F3_LHU:  result = {16'd0, sh[15:0]};
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/instruction_l.sv
// Multi-cycle RV32I load unit: effective address, one or two word reads from
// data RAM (for boundary-straddling loads), byte extraction and write-back.
module instruction_l
    import rv32i_pkg::*;
#(
    parameter int RAM_ADDR_W  = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic [31:0]           iIR,
    input  logic [31:0]           iREG_OUT1,
    output logic [4:0]            oRS1,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oERR,
    output logic [4:0]            oRD,
    output logic                  oREG_WE,
    output logic [31:0]           oREG_IN,
    output logic                  oRAM_CE,
    output logic                  oRAM_RD,
    output logic                  oRAM_WR,
    output logic [RAM_ADDR_W-1:0] oRAM_ADDR,
    input  logic [31:0]           iRAM_DATA
);

    localparam logic [2:0] LAT_M1 = 3'(RAM_LATENCY - 1);

    load_state_e           state_q, state_d;
    logic [2:0]            func3_q, func3_d;
    logic [1:0]            off_q, off_d;
    logic [4:0]            rd_q, rd_d;
    logic                  err_q, err_d;
    logic                  split_q, split_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [RAM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]           d0_q, d0_d;
    logic [31:0]           reg_in_q, reg_in_d;

    logic signed [31:0]    imm_s;
    logic signed [31:0]    ea;
    logic [31:0]           al_d1, al_d0, al_res;
    logic                  unused_ok;

    assign imm_s     = {{20{iIR[31]}}, iIR[31:20]};
    assign ea        = $signed(iREG_OUT1) + imm_s;
    assign unused_ok = ^{ea[31:RAM_ADDR_W+2], iIR[6:0]};

    // Second-word capture combines fresh RAM data with the held first word.
    assign al_d1 = (state_q == LD_WAIT1) ? iRAM_DATA : 32'd0;
    assign al_d0 = (state_q == LD_WAIT1) ? d0_q : iRAM_DATA;

    load_align u_align (
        .d1     (al_d1),
        .d0     (al_d0),
        .off    (off_q),
        .func3  (func3_q),
        .result (al_res)
    );

    always_comb begin
        state_d  = state_q;
        func3_d  = func3_q;
        off_d    = off_q;
        rd_d     = rd_q;
        err_d    = err_q;
        split_d  = split_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        d0_d     = d0_q;
        reg_in_d = reg_in_q;
        case (state_q)
            LD_IDLE: begin
                if (iSTART) begin
                    func3_d = iIR[14:12];
                    rd_d    = iIR[11:7];
                    off_d   = ea[1:0];
                    split_d = load_split(iIR[14:12], ea[1:0]);
                    if (f3_legal(iIR[14:12])) begin
                        state_d = LD_RD0;
                        err_d   = 1'b0;
                        cnt_d   = LAT_M1;
                        addr_d  = ea[RAM_ADDR_W+1:2];
                    end else begin
                        state_d = LD_WB;
                        err_d   = 1'b1;
                    end
                end
            end
            // The strobe cycle is the first cycle of the first latency window.
            LD_RD0, LD_WAIT0: begin
                if (cnt_q == 3'd0) begin
                    d0_d = iRAM_DATA;
                    if (split_q) begin
                        state_d = LD_RD1;
                        cnt_d   = LAT_M1;
                        addr_d  = addr_q + 1'b1;
                    end else begin
                        state_d  = LD_WB;
                        reg_in_d = al_res;
                    end
                end else begin
                    state_d = LD_WAIT0;
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            LD_RD1: state_d = LD_WAIT1;
            LD_WAIT1: begin
                if (cnt_q == 3'd0) begin
                    state_d  = LD_WB;
                    reg_in_d = al_res;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LD_WB:   state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= LD_IDLE;
            func3_q  <= 3'd0;
            off_q    <= 2'd0;
            rd_q     <= 5'd0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
            cnt_q    <= 3'd0;
            addr_q   <= '0;
            d0_q     <= 32'd0;
            reg_in_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            func3_q  <= func3_d;
            off_q    <= off_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            split_q  <= split_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            d0_q     <= d0_d;
            reg_in_q <= reg_in_d;
        end
    end

    assign oRS1      = iIR[19:15];
    assign oBUSY     = (state_q != LD_IDLE);
    assign oDONE     = (state_q == LD_WB);
    assign oERR      = (state_q == LD_WB) && err_q;
    assign oREG_WE   = (state_q == LD_WB) && !err_q && (rd_q != 5'd0);
    assign oREG_IN   = reg_in_q;
    assign oRD       = rd_q;
    assign oRAM_CE   = (state_q == LD_RD0) || (state_q == LD_RD1);
    assign oRAM_RD   = oRAM_CE;
    assign oRAM_WR   = 1'b0;
    assign oRAM_ADDR = addr_q;

endmodule

// File: tb/tb_instruction_l.sv
// Directed bench for instruction_l: one instance at RAM_LATENCY=1 and one at
// RAM_LATENCY=3, each reading from the same small RAM image.
module tb_instruction_l;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start3;
    logic [31:0] ir, rs1_v;

    logic [4:0]  rs1_o, rd_o, rs1_o3, rd_o3;
    logic        busy, done, err, we, ce, rdstb, wr;
    logic        busy3, done3, err3, we3, ce3, rdstb3, wr3;
    logic [31:0] reg_in, reg_in3, ram_data, ram_data3;
    logic [7:0]  ram_addr, ram_addr3;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ram_data  = mem[ram_addr];
    assign ram_data3 = mem[ram_addr3];

    instruction_l #(.RAM_ADDR_W(8), .RAM_LATENCY(1)) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .iIR(ir), .iREG_OUT1(rs1_v),
        .oRS1(rs1_o), .oBUSY(busy), .oDONE(done), .oERR(err), .oRD(rd_o),
        .oREG_WE(we), .oREG_IN(reg_in), .oRAM_CE(ce), .oRAM_RD(rdstb),
        .oRAM_WR(wr), .oRAM_ADDR(ram_addr), .iRAM_DATA(ram_data)
    );

    instruction_l #(.RAM_ADDR_W(8), .RAM_LATENCY(3)) dut3 (
        .iCLK(clk), .iRST(rst), .iSTART(start3), .iIR(ir), .iREG_OUT1(rs1_v),
        .oRS1(rs1_o3), .oBUSY(busy3), .oDONE(done3), .oERR(err3), .oRD(rd_o3),
        .oREG_WE(we3), .oREG_IN(reg_in3), .oRAM_CE(ce3), .oRAM_RD(rdstb3),
        .oRAM_WR(wr3), .oRAM_ADDR(ram_addr3), .iRAM_DATA(ram_data3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one load for a single cycle; returns in cycle k+1.
    task automatic issue(input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] rs1, input logic [11:0] imm,
                         input logic use3);
        ir    = {imm, 5'd1, f3, rd, 7'b0000011};
        rs1_v = rs1;
        if (use3) start3 = 1'b1;
        else      start  = 1'b1;
        step();
        start  = 1'b0;
        start3 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h99AABBCC;
        mem[2]   = 32'hAABBCCDD;
        mem[3]   = 32'h11223344;
        mem[4]   = 32'h80FF7F01;
        mem[5]   = 32'hDEADBEEF;
        mem[255] = 32'h55667788;

        rst = 1'b1; start = 1'b0; start3 = 1'b0; ir = 32'h0; rs1_v = 32'h0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_done",   32'(done),     32'd0);
        chk("rst_err",    32'(err),      32'd0);
        chk("rst_we",     32'(we),       32'd0);
        chk("rst_ce",     32'(ce),       32'd0);
        chk("rst_rd",     32'(rd_o),     32'd0);
        chk("rst_regin",  reg_in,        32'd0);
        chk("rst_addr",   32'(ram_addr), 32'd0);
        chk("ram_wr",     32'(wr),       32'd0);
        step();

        // LW aligned: ea = 0x10 + 4 = 0x14 -> word 5
        issue(3'd2, 5'd5, 32'h10, 12'h004, 1'b0);
        chk("lw_rs1",     32'(rs1_o),    32'd1);
        chk("lw_ce",      32'(ce),       32'd1);
        chk("lw_rdstb",   32'(rdstb),    32'd1);
        chk("lw_addr",    32'(ram_addr), 32'd5);
        chk("lw_busy",    32'(busy),     32'd1);
        chk("lw_nodone",  32'(done),     32'd0);
        step();
        chk("lw_done",    32'(done),     32'd1);
        chk("lw_we",      32'(we),       32'd1);
        chk("lw_data",    reg_in,        32'hDEADBEEF);
        chk("lw_rd",      32'(rd_o),     32'd5);
        chk("lw_ce_off",  32'(ce),       32'd0);
        step();
        chk("lw_idle",    32'(busy),     32'd0);
        chk("lw_hold",    reg_in,        32'hDEADBEEF);
        chk("lw_we_off",  32'(we),       32'd0);

        // LB / LBU at ea 0x13: byte 3 of 0x80FF7F01 is 0x80
        issue(3'd0, 5'd6, 32'h13, 12'h000, 1'b0);
        chk("lb_addr",    32'(ram_addr), 32'd4);
        step();
        chk("lb_data",    reg_in,        32'hFFFFFF80);
        step();
        issue(3'd4, 5'd6, 32'h13, 12'h000, 1'b0);
        step();
        chk("lbu_data",   reg_in,        32'h00000080);
        chk("lbu_we",     32'(we),       32'd1);
        step();

        // LH split at ea 0x0B, with a second start while busy that must be ignored
        issue(3'd1, 5'd8, 32'h8, 12'h003, 1'b0);
        chk("lh_addr0",   32'(ram_addr), 32'd2);
        chk("lh_ce0",     32'(ce),       32'd1);
        ir = {12'h004, 5'd1, 3'd2, 5'd7, 7'b0000011}; rs1_v = 32'h10; start = 1'b1;
        step();
        start = 1'b0;
        chk("lh_addr1",   32'(ram_addr), 32'd3);
        chk("lh_ce1",     32'(ce),       32'd1);
        chk("lh_nodone1", 32'(done),     32'd0);
        step();
        chk("lh_ce_gap",  32'(ce),       32'd0);
        chk("lh_nodone3", 32'(done),     32'd0);
        step();
        chk("lh_done",    32'(done),     32'd1);
        chk("lh_data",    reg_in,        32'h000044AA);
        chk("lh_rd",      32'(rd_o),     32'd8);
        step();
        chk("busy_ignore", 32'(busy),    32'd0);

        // LW split at ea 0x3FD: words 0xFF then wrap to 0x00
        issue(3'd2, 5'd9, 32'h400, 12'hFFD, 1'b0);
        chk("wrap_addr0", 32'(ram_addr), 32'hFF);
        step();
        chk("wrap_addr1", 32'(ram_addr), 32'h00);
        chk("wrap_ce1",   32'(ce),       32'd1);
        step(); step();
        chk("wrap_done",  32'(done),     32'd1);
        chk("wrap_data",  reg_in,        32'hCC556677);
        step();

        // Illegal func3: write-back cycle right after accept, no strobe
        issue(3'd3, 5'd10, 32'h10, 12'h004, 1'b0);
        chk("ill_done",   32'(done),     32'd1);
        chk("ill_err",    32'(err),      32'd1);
        chk("ill_we",     32'(we),       32'd0);
        chk("ill_ce",     32'(ce),       32'd0);
        chk("ill_hold",   reg_in,        32'hCC556677);
        step();
        chk("ill_err_off", 32'(err),     32'd0);

        // rd = 0: access runs but no register write
        issue(3'd2, 5'd0, 32'h10, 12'h004, 1'b0);
        chk("rd0_ce",     32'(ce),       32'd1);
        step();
        chk("rd0_done",   32'(done),     32'd1);
        chk("rd0_we",     32'(we),       32'd0);
        step();

        // RAM_LATENCY = 3 aligned LW: WB at k+4
        issue(3'd2, 5'd5, 32'h10, 12'h004, 1'b1);
        chk("l3_ce",      32'(ce3),      32'd1);
        chk("l3_addr",    32'(ram_addr3), 32'd5);
        step();
        chk("l3_nodone2", 32'(done3),    32'd0);
        step();
        chk("l3_nodone3", 32'(done3),    32'd0);
        step();
        chk("l3_done",    32'(done3),    32'd1);
        chk("l3_we",      32'(we3),      32'd1);
        chk("l3_data",    reg_in3,       32'hDEADBEEF);
        step();

        // Reset during WAIT0 aborts the load
        issue(3'd0, 5'd6, 32'h13, 12'h000, 1'b1);
        step();
        chk("abort_busy_pre", 32'(busy3), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy3),    32'd0);
        chk("abort_done", 32'(done3),    32'd0);
        chk("abort_we",   32'(we3),      32'd0);
        chk("abort_regin", reg_in3,      32'd0);
        chk("abort_addr", 32'(ram_addr3), 32'd0);
        chk("abort_rd",   32'(rd_o3),    32'd0);
        step();
        chk("abort_nodone1", 32'(done3), 32'd0);
        step();
        chk("abort_nodone2", 32'(done3), 32'd0);
        chk("abort_regin2",  reg_in3,    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
